// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mips_pkg;

  // Primary opcodes (instr[31:26]) understood by the controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation selects.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand selects.
  localparam logic [1:0] SRCB_RT       = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  // PC source selects.
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // True for every opcode the decode step knows how to dispatch.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       i_or_d;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic       mem_err;

  // Controller side: consumes status, drives every select and enable.
  modport master (
    input  opcode, zero, mem_ready,
    output reg_dst, mem_to_reg, reg_write, mem_read, mem_write, ir_write,
           i_or_d, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_op, mem_err
  );

  // Datapath side: supplies status, receives the controls.
  modport slave (
    output opcode, zero, mem_ready,
    input  reg_dst, mem_to_reg, reg_write, mem_read, mem_write, ir_write,
           i_or_d, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_op, mem_err
  );
endinterface

// File: rtl/mips_mem_watchdog.sv
// Counts cycles spent waiting on memory; flags expiry on the last allowed cycle.
module mips_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,     // state changed or wait aborted: restart count
  input  logic inc,     // waiting on memory this cycle
  output logic expire   // this is the final wait cycle and memory is still not ready
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a new wait always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready response in the final cycle suppresses expiry because inc is low.
  assign expire = inc && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with a memory-ready watchdog.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  state_t state_q;
  state_t state_d;

  logic wd_inc;
  logic wd_clr;
  logic wd_expire;

  logic       reg_dst_c, mem_to_reg_c, reg_write_c, mem_read_c, mem_write_c;
  logic       ir_write_c, i_or_d_c, alu_src_a_c, pc_en_c, illegal_op_c, mem_err_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_src_c;
  logic       pc_write, branch;

  // Watchdog runs only in states that wait on memory.
  always_comb begin
    wd_inc = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) &&
             !bus.mem_ready;
    wd_clr = (state_d != state_q) || wd_expire;
  end

  mips_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a watchdog expiry abandons the access and refetches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else if (wd_expire) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (wd_expire) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready || wd_expire) state_d = S_FETCH;
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode from state; reset masks every enable and pulse.
  always_comb begin
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    i_or_d_c     = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_RT;
    alu_op_c     = ALU_ADD;
    pc_src_c     = PC_ALU;
    pc_write     = 1'b0;
    branch       = 1'b0;
    illegal_op_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        ir_write_c  = bus.mem_ready;
        pc_write    = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b_c  = SRCB_SEXT_SH2;
        illegal_op_c = !is_legal_op(bus.opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_SEXT;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_SUB;
        pc_src_c    = PC_ALUOUT;
        branch      = 1'b1;
      end
      S_ADDIWB: reg_write_c = 1'b1;
      S_JEX: begin
        pc_src_c = PC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    pc_en_c   = pc_write || (branch && bus.zero);
    mem_err_c = wd_expire;
    if (rst) begin
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      reg_write_c  = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      i_or_d_c     = 1'b0;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = SRCB_FOUR;
      alu_op_c     = ALU_ADD;
      pc_src_c     = PC_ALU;
      pc_en_c      = 1'b0;
      illegal_op_c = 1'b0;
      mem_err_c    = 1'b0;
    end
  end

  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.ir_write   = ir_write_c;
  assign bus.i_or_d     = i_or_d_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.pc_en      = pc_en_c;
  assign bus.illegal_op = illegal_op_c;
  assign bus.mem_err    = mem_err_c;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle expected control words via a scoreboard.
module tb_mips_mc_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout:
  // {reg_dst, mem_to_reg, reg_write, mem_read, mem_write, ir_write, i_or_d,
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], pc_en, illegal_op, mem_err}
  function automatic logic [16:0] ctl(input bit rd, input bit m2r, input bit rw,
                                      input bit mr, input bit mw, input bit irw,
                                      input bit iod, input bit sa, input bit [1:0] sb,
                                      input bit [1:0] aop, input bit [1:0] pcs,
                                      input bit pce, input bit ill, input bit err);
    return {rd, m2r, rw, mr, mw, irw, iod, sa, sb, aop, pcs, pce, ill, err};
  endfunction

  logic [16:0] obs;
  assign obs = {bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.pc_en, bus.illegal_op, bus.mem_err};

  // Expected words taken directly from the state table.
  logic [16:0] E_RST, E_FETCH_RDY, E_FETCH_WAIT, E_FETCH_ERR, E_DECODE, E_DECODE_ILL;
  logic [16:0] E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR, E_MEMWR_ERR;
  logic [16:0] E_RTYPEEX, E_RTYPEWB, E_BEQ_T, E_BEQ_NT, E_ADDIEX, E_ADDIWB, E_JEX;

  initial begin
    //                 rd m2r rw mr mw irw iod sa  sb     aop    pcs   pce ill err
    E_RST        = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    E_FETCH_RDY  = ctl(0, 0, 0, 1, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0);
    E_FETCH_WAIT = ctl(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    E_FETCH_ERR  = ctl(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 1);
    E_DECODE     = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
    E_DECODE_ILL = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1, 0);
    E_MEMADR     = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    E_MEMRD      = ctl(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    E_MEMWB      = ctl(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    E_MEMWR      = ctl(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    E_MEMWR_ERR  = ctl(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    E_RTYPEEX    = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    E_RTYPEWB    = ctl(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    E_BEQ_T      = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0, 0);
    E_BEQ_NT     = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0, 0);
    E_ADDIEX     = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    E_ADDIWB     = ctl(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    E_JEX        = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0);
  end

  // One clock cycle: drive inputs, queue the expected word, compare at the falling edge.
  task automatic cyc(input bit r, input logic [5:0] op, input bit z, input bit rdy,
                     input logic [16:0] e, input string tag);
    logic [16:0] exp_w;
    string       t;
    rst           = r;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    exp_w = exp_q.pop_front();
    t     = tag_q.pop_front();
    checks++;
    txn++;
    assert (obs === exp_w) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", t, obs, exp_w);
    end
    $display("txn %0d %s observed=%05h expected=%05h", txn, t, obs, exp_w);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with memory ready: enables stay masked.
    cyc(1, 6'b000000, 0, 1, E_RST, "reset_0");
    cyc(1, 6'b000000, 0, 1, E_RST, "reset_1");

    // R-type, zero-wait: 4 cycles, write-back via rd in cycle 4.
    cyc(0, 6'b000000, 0, 1, E_FETCH_RDY, "rtype_fetch");
    cyc(0, 6'b000000, 0, 1, E_DECODE,    "rtype_decode");
    cyc(0, 6'b000000, 0, 1, E_RTYPEEX,   "rtype_ex");
    cyc(0, 6'b000000, 0, 1, E_RTYPEWB,   "rtype_wb");

    // lw with three wait cycles in MEMRD.
    cyc(0, 6'b100011, 0, 1, E_FETCH_RDY, "lw_fetch");
    cyc(0, 6'b100011, 0, 1, E_DECODE,    "lw_decode");
    cyc(0, 6'b100011, 0, 1, E_MEMADR,    "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(0, 6'b100011, 0, 0, E_MEMRD, "lw_memrd_wait");
    cyc(0, 6'b100011, 0, 1, E_MEMRD,     "lw_memrd_done");
    cyc(0, 6'b100011, 0, 1, E_MEMWB,     "lw_memwb");

    // beq taken then not taken.
    cyc(0, 6'b000100, 1, 1, E_FETCH_RDY, "beq_t_fetch");
    cyc(0, 6'b000100, 1, 1, E_DECODE,    "beq_t_decode");
    cyc(0, 6'b000100, 1, 1, E_BEQ_T,     "beq_t_ex");
    cyc(0, 6'b000100, 0, 1, E_FETCH_RDY, "beq_nt_fetch");
    cyc(0, 6'b000100, 0, 1, E_DECODE,    "beq_nt_decode");
    cyc(0, 6'b000100, 0, 1, E_BEQ_NT,    "beq_nt_ex");

    // addi and j, zero-wait.
    cyc(0, 6'b001000, 0, 1, E_FETCH_RDY, "addi_fetch");
    cyc(0, 6'b001000, 0, 1, E_DECODE,    "addi_decode");
    cyc(0, 6'b001000, 0, 1, E_ADDIEX,    "addi_ex");
    cyc(0, 6'b001000, 0, 1, E_ADDIWB,    "addi_wb");
    cyc(0, 6'b000010, 0, 1, E_FETCH_RDY, "j_fetch");
    cyc(0, 6'b000010, 0, 1, E_DECODE,    "j_decode");
    cyc(0, 6'b000010, 0, 1, E_JEX,       "j_ex");

    // sw with memory stuck: error on the 16th MEMWR cycle, then back to FETCH.
    cyc(0, 6'b101011, 0, 1, E_FETCH_RDY, "sw_fetch");
    cyc(0, 6'b101011, 0, 1, E_DECODE,    "sw_decode");
    cyc(0, 6'b101011, 0, 1, E_MEMADR,    "sw_memadr");
    for (int i = 0; i < 15; i++) cyc(0, 6'b101011, 0, 0, E_MEMWR, "sw_memwr_wait");
    cyc(0, 6'b101011, 0, 0, E_MEMWR_ERR, "sw_memwr_timeout");

    // Fetch waits 15 cycles, ready arrives in the last allowed cycle: no error.
    for (int i = 0; i < 15; i++) cyc(0, 6'b000010, 0, 0, E_FETCH_WAIT, "fetch_wait");
    cyc(0, 6'b000010, 0, 1, E_FETCH_RDY, "fetch_ready_at_limit");
    cyc(0, 6'b000010, 0, 1, E_DECODE,    "j2_decode");
    cyc(0, 6'b000010, 0, 1, E_JEX,       "j2_ex");

    // Fetch stuck: error on the 16th cycle, counter restarts afterwards.
    for (int i = 0; i < 15; i++) cyc(0, 6'b111111, 0, 0, E_FETCH_WAIT, "fetch_stuck");
    cyc(0, 6'b111111, 0, 0, E_FETCH_ERR,  "fetch_timeout");
    cyc(0, 6'b111111, 0, 0, E_FETCH_WAIT, "fetch_after_timeout");

    // Illegal opcode: pulse in DECODE, straight back to FETCH.
    cyc(0, 6'b111111, 0, 1, E_FETCH_RDY,  "ill_fetch");
    cyc(0, 6'b111111, 0, 1, E_DECODE_ILL, "ill_decode");
    cyc(0, 6'b000000, 0, 1, E_FETCH_RDY,  "ill_refetch");

    // Reset during RTYPEEX: write-back is never reached.
    cyc(0, 6'b000000, 0, 1, E_DECODE,    "rst_mid_decode");
    cyc(1, 6'b000000, 0, 1, E_RST,       "rst_mid_ex");
    cyc(0, 6'b000000, 0, 1, E_FETCH_RDY, "rst_mid_refetch");
    cyc(0, 6'b000000, 0, 1, E_DECODE,    "rst_mid_decode2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle control FSM for the MIPS core.
- Sequences the shared ALU/memory datapath through fetch, decode, execute, memory and write-back steps.
- Drives every datapath select and enable, including reg_dst, which is the select of the 5-bit write-register mux (0 = rt, 1 = rd).
- Adds a memory ready handshake with a watchdog so a slow or stuck memory cannot hang the core.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready in any memory state before aborting.
- CNT_W, 5: width of the watchdog counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- reg_dst  out  1  write-register mux select (0 = rt, 1 = rd)
- mem_to_reg  out  1  write-back data select (0 = ALUOut, 1 = MDR)
- reg_write  out  1  register file write enable
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- i_or_d  out  1  address select (0 = PC, 1 = ALUOut)
- alu_src_a  out  1  ALU A select (0 = PC, 1 = rs)
- alu_src_b  out  2  ALU B select (00 = rt, 01 = 4, 10 = signext, 11 = signext<<2)
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load; equals pc_write | (branch & zero)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset:
  - rst is sampled at the clk edge; the state goes to FETCH and the watchdog clears to 0.
  - While rst=1, reg_write, mem_write, mem_read, ir_write, pc_en, illegal_op and mem_err are forced to 0.
  - Every other output takes its FETCH value (all 0 except alu_src_b = 01).
  - Reset asserted mid-instruction abandons it with no further writes.
- Output style:
  - All outputs are decoded from state.
  - Only ir_write and pc_en in FETCH additionally depend on mem_ready; pc_en in BEQEX depends on zero.
- States and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
    - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
    - Otherwise stay in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other opcode: illegal_op=1 for that cycle, go to FETCH
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: mem_read=1, i_or_d=1. Advance to MEMWB on mem_ready.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
  - MEMWR: mem_write=1, i_or_d=1. Go to FETCH on mem_ready.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPEWB.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
  - JEX: pc_src=10, pc_write=1 -> FETCH.
- Watchdog (FETCH, MEMRD, MEMWR only):
  - The counter increments each cycle mem_ready=0 and clears on any state change.
  - If mem_ready=0 when the counter equals MEM_TIMEOUT-1: mem_err=1 for that cycle, no writes, go to FETCH.
  - mem_ready=1 in that same cycle wins: normal completion, no error.
- Cycle counts with zero-wait memory (mem_ready tied to 1):
  - R-type, addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, j: 3 cycles
- reg_write is never asserted in the same cycle as mem_write or ir_write.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the 4-bit state enum
  - alu_op, alu_src_b and pc_src encodings
- One sub-module, mips_mem_watchdog: counter, clear/enable inputs, expire output.

Test Plan:
- rst=1 for 2 cycles with mem_ready=1 -> all enables 0 and state FETCH. After release: ir_write=1 and pc_en=1 in the first cycle, DECODE in the next.
- R-type (opcode 000000), mem_ready=1 -> 4-cycle sequence. reg_write=1 with reg_dst=1 exactly in cycle 4.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles. Then MEMWB with reg_dst=0, mem_to_reg=1, reg_write=1. No mem_err.
- beq (000100): zero=1 -> pc_en=1, pc_src=01 in BEQEX. Rerun with zero=0 -> pc_en=0.
- sw (101011), mem_ready stuck 0 -> mem_err pulses in the 16th MEMWR cycle, mem_write never completes, next state FETCH.
- opcode 111111 -> illegal_op=1 in DECODE, return to FETCH, no reg_write or mem_write asserted. rst asserted in RTYPEEX -> RTYPEWB is never entered.
